// File: rtl/confreg_mmio_if.sv
// -----------------------------------------------------------------------------
// confreg_mmio_if
// CPU data-port bundle for the confreg_mmio register block.
//   req    : access request, one cycle per access
//   wen    : 1 = write, 0 = read (qualified by req)
//   addr   : byte address, ADDR_W bits
//   wstrb  : per-byte write enables
//   wdata  : write data
//   rvalid : read data valid, one cycle after a read request
//   rdata  : read data, held while rvalid is low
// Modports: master (CPU side), slave (register block side).
// -----------------------------------------------------------------------------
interface confreg_mmio_if #(
   parameter int unsigned ADDR_W = 16
) ();
   logic              req;
   logic              wen;
   logic [ADDR_W-1:0] addr;
   logic [3:0]        wstrb;
   logic [31:0]       wdata;
   logic              rvalid;
   logic [31:0]       rdata;

   modport master (
      output req, wen, addr, wstrb, wdata,
      input  rvalid, rdata
   );

   modport slave (
      input  req, wen, addr, wstrb, wdata,
      output rvalid, rdata
   );
endinterface

// File: rtl/confreg_mmio.sv
// -----------------------------------------------------------------------------
// confreg_mmio
// Memory-mapped configuration/IO registers for the thinpad CPU data port.
// Register map (byte offset, word decoded):
//   0x00 LED     RW  bits [LED_W-1:0]
//   0x04 SW      RO  2-flop synchronised dip_sw, zero-extended
//   0x08 MODE    RW  bit0 = blink enable
//   0x0C TIMER   RW  free-running 32-bit counter (only with CONFREG_TIMER_EN)
//   0x10 SCRATCH RW  32 bits
// Reads return registered data one cycle after the request.
// Ports:
//   clk    : system clock, rising edge
//   resetn : synchronous active-low reset
//   bus    : confreg_mmio_if slave (req/wen/addr/wstrb/wdata/rvalid/rdata)
//   dip_sw : asynchronous switch inputs
//   leds   : registered LED drive, 1 = lit
// Build option: define CONFREG_TIMER_EN to implement the TIMER register;
// otherwise offset 0x0C reads 0 and ignores writes.
// -----------------------------------------------------------------------------
module confreg_mmio #(
   parameter int unsigned LED_W       = 16,
   parameter int unsigned SW_W        = 32,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned BLINK_SHIFT = 24
) (
   input  logic             clk,
   input  logic             resetn,
   confreg_mmio_if.slave    bus,
   input  logic [SW_W-1:0]  dip_sw,
   output logic [LED_W-1:0] leds
);

   // Replace only the bytes selected by be.
   function automatic logic [31:0] merge(input logic [31:0] old_val,
                                         input logic [31:0] new_val,
                                         input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

   // ---------------- address decode ----------------
   logic       hit;
   logic [2:0] off;
   logic       wr;
   logic       rd;
   logic       wr_led;
   logic       wr_mode;
   logic       wr_scr;
   logic       unused_addr_lsb;

   if (ADDR_W > 5) begin : g_hi_decode
      assign hit = (bus.addr[ADDR_W-1:5] == '0);
   end else begin : g_no_hi_decode
      assign hit = 1'b1;
   end

   assign off             = bus.addr[4:2];
   assign unused_addr_lsb = ^bus.addr[1:0];
   assign wr              = bus.req & bus.wen & hit;
   assign rd              = bus.req & ~bus.wen;
   assign wr_led          = wr && (off == 3'd0);
   // Only a write that actually touches bit0 (byte 0) restarts the blink.
   assign wr_mode         = wr && (off == 3'd2) && bus.wstrb[0];
   assign wr_scr          = wr && (off == 3'd4);

   // ---------------- registers ----------------
   logic [LED_W-1:0]       led_q;
   logic                   mode_q;
   logic [31:0]            scr_q;
   logic [SW_W-1:0]        sw_meta_q;
   logic [SW_W-1:0]        sw_sync_q;
   logic [BLINK_SHIFT-1:0] cnt_q;
   logic                   phase_q;
   logic [LED_W-1:0]       leds_q;
   logic                   rvalid_q;
   logic [31:0]            rdata_q;
   logic [31:0]            led_merged;

   assign led_merged = merge(32'(led_q), bus.wdata, bus.wstrb);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         led_q  <= '0;
         mode_q <= 1'b0;
         scr_q  <= '0;
      end else begin
         if (wr_led)  led_q  <= led_merged[LED_W-1:0];
         if (wr_mode) mode_q <= bus.wdata[0];
         if (wr_scr)  scr_q  <= merge(scr_q, bus.wdata, bus.wstrb);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         sw_meta_q <= dip_sw;
         sw_sync_q <= sw_meta_q;
      end
   end

   // Blink counter: phase flips on wrap; a MODE write restarts lit.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else if (wr_mode) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else begin
         cnt_q <= cnt_q + BLINK_SHIFT'(1);
         if (&cnt_q) phase_q <= ~phase_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         leds_q <= '0;
      end else begin
         leds_q <= mode_q ? (led_q & {LED_W{phase_q}}) : led_q;
      end
   end

`ifdef CONFREG_TIMER_EN
   logic [31:0] timer_q;
   logic        wr_tmr;

   assign wr_tmr = wr && (off == 3'd3);

   // A write wins over the increment in the same cycle.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         timer_q <= '0;
      end else if (wr_tmr) begin
         timer_q <= merge(timer_q, bus.wdata, bus.wstrb);
      end else begin
         timer_q <= timer_q + 32'd1;
      end
   end
`endif

   // ---------------- read path ----------------
   logic [31:0] rd_val;

   always_comb begin
      rd_val = '0;
      if (hit) begin
         case (off)
            3'd0:    rd_val = 32'(led_q);
            3'd1:    rd_val = 32'(sw_sync_q);
            3'd2:    rd_val = {31'd0, mode_q};
`ifdef CONFREG_TIMER_EN
            3'd3:    rd_val = timer_q;
`endif
            3'd4:    rd_val = scr_q;
            default: rd_val = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= rd;
         if (rd) rdata_q <= rd_val;
      end
   end

   assign bus.rvalid = rvalid_q;
   assign bus.rdata  = rdata_q;
   assign leds       = leds_q;

endmodule
